// File: rtl/sample_delay_mc_pkg.sv
// sample_delay_pkg: shared state encoding, defaults and SDRAM address packing
package sample_delay_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_W = 3'd2,
    RD     = 3'd3,
    WAIT_R = 3'd4,
    OUT    = 3'd5
  } state_t;
  localparam int DEFAULT_DEPTH   = 32768;
  localparam int DEFAULT_TIMEOUT = 255;
  function automatic logic [63:0] addr_pack(input logic [31:0] ch, input logic [31:0] ptr, input int ptr_w);
    return (64'(ch) << ptr_w) | 64'(ptr);
  endfunction
endpackage

// File: rtl/sample_delay_mc_if.sv
// sample_delay_if: sample stream in/out, delay control and SDRAM port bundle
interface sample_delay_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 1,
  parameter int PTR_W  = 15,
  parameter int ADDR_W = 25
);
  logic [DATA_W-1:0] idata;
  logic [CH_W-1:0]   ichannel;
  logic              ivalid;
  logic              iready;
  logic [DATA_W-1:0] odata;
  logic [CH_W-1:0]   ochannel;
  logic              ovalid;
  logic              oready;
  logic [PTR_W-1:0]  delay;
  logic              bypass;
  logic              write;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              read;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              read_ready;
  logic              err;
  logic [2:0]        state;
  modport slave (
    input  idata, ichannel, ivalid, oready, delay, bypass, rdata, busy, read_ready,
    output iready, odata, ochannel, ovalid, write, waddr, wdata, read, raddr, err, state
  );
  modport master (
    output idata, ichannel, ivalid, oready, delay, bypass, rdata, busy, read_ready,
    input  iready, odata, ochannel, ovalid, write, waddr, wdata, read, raddr, err, state
  );
endinterface

// File: rtl/sample_delay_mc_bus_wait_timer.sv
// bus_wait_timer: tracks busy high-then-low completion and a bounded wait counter
module bus_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic busy,
  output logic done,
  output logic tout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          seen;
  assign done = en && seen && !busy;
  assign tout = en && cnt == CW'(TIMEOUT);
  // remember that busy went high and count wait cycles, saturating at the limit
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else if (en) begin
      seen <= seen | busy;
      if (!tout) cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sample_delay_mc.sv
// sample_delay_mc: per-channel SDRAM ring delay with bypass and bus timeout
module sample_delay_mc
  import sample_delay_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 1,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int PTR_W   = 15,
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic          clk50,
  input logic          rst_n,
  sample_delay_if.slave bus
);
  state_t            state, state_n;
  logic [CH_W-1:0]   ch;
  logic [DATA_W-1:0] rbuf, rval;
  logic              got;
  logic [PTR_W-1:0]  wptr, fill, delay_lat, rptr;
  logic              done, tout, wait_en, clr, fire_in, fire_out, bad_ch, eof;
  assign fire_in   = bus.ivalid && bus.iready;
  assign fire_out  = bus.ovalid && bus.oready;
  assign bad_ch    = 32'(bus.ichannel) >= 32'(NUM_CH);
  assign eof       = 32'(ch) == 32'(NUM_CH - 1);
  assign rptr      = wptr - delay_lat;
  assign wait_en   = state == WAIT_W || state == WAIT_R;
  assign clr       = state == WR || state == RD;
  assign rval      = got ? rbuf : (bus.read_ready ? bus.rdata : '0);
  assign bus.write  = state == WR;
  assign bus.read   = state == RD;
  assign bus.ovalid = state == OUT;
  assign bus.state  = state;
  bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk50(clk50),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (wait_en),
    .busy (bus.busy),
    .done (done),
    .tout (tout)
  );
  // state register
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next-state: one SDRAM write then one read per accepted sample, unless bypassed
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (fire_in && !bad_ch) ? (bus.bypass ? OUT : WR) : IDLE;
      WR:      state_n = WAIT_W;
      WAIT_W:  state_n = (done || tout) ? RD : WAIT_W;
      RD:      state_n = WAIT_R;
      WAIT_R:  state_n = (done || tout) ? OUT : WAIT_R;
      OUT:     state_n = fire_out ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  // datapath: capture, address generation, read-back latch and frame-end ring update
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      bus.iready   <= 1'b0;
      bus.odata    <= '0;
      bus.ochannel <= '0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      bus.raddr    <= '0;
      bus.err      <= 1'b0;
      ch           <= '0;
      rbuf         <= '0;
      got          <= 1'b0;
      wptr         <= '0;
      fill         <= '0;
      delay_lat    <= '0;
    end else begin
      bus.iready <= state_n == IDLE;
      if (state == IDLE && fire_in) begin
        ch           <= bus.ichannel;
        bus.odata    <= bus.idata;
        bus.ochannel <= bus.ichannel;
        bus.waddr    <= ADDR_W'(addr_pack(32'(bus.ichannel), 32'(wptr), PTR_W));
        bus.wdata    <= bus.idata;
      end
      if (state == WR) begin
        bus.raddr <= ADDR_W'(addr_pack(32'(ch), 32'(rptr), PTR_W));
        got       <= 1'b0;
      end
      if (state == WAIT_R && bus.read_ready && !got) begin
        rbuf <= bus.rdata;
        got  <= 1'b1;
      end
      if (state == WAIT_R && (done || tout)) bus.odata <= (done && fill >= delay_lat) ? rval : '0;
      if (wait_en && tout && !done) bus.err <= 1'b1;
      if (fire_out && eof) begin
        wptr      <= wptr + PTR_W'(1);
        delay_lat <= bus.delay;
        if (32'(fill) != 32'(DEPTH - 1)) fill <= fill + PTR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sample_delay_mc.sv
// tb_sample_delay_mc: directed scoreboard bench with a behavioural SDRAM and ring model
module tb_sample_delay_mc;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int TO = 20;
  typedef struct {logic [0:0] ch; logic [15:0] d;} exp_t;
  logic clk50 = 1'b0;
  logic rst_n = 1'b1;
  logic stuck = 1'b0;
  logic [2:0] bcnt = 3'd0;
  logic rpend = 1'b0;
  logic [15:0] mem [32];
  logic [15:0] mem_m [2][DP];
  int m_wptr, m_fill, m_dlat;
  int n_vec, n_bad;
  int wcnt, rcnt, both;
  logic [4:0] last_waddr, last_raddr;
  exp_t q[$];
  sample_delay_if #(.DATA_W(DW), .CH_W(1), .PTR_W(4), .ADDR_W(5)) bus ();
  sample_delay_mc #(
    .DATA_W(DW), .NUM_CH(2), .CH_W(1), .DEPTH(DP), .PTR_W(4), .ADDR_W(5), .TIMEOUT(TO)
  ) dut (
    .clk50(clk50),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk50 = ~clk50;
  assign bus.busy = bcnt != 3'd0;
  // SDRAM: store on write, busy for three cycles per op, read data with read_ready mid-op
  always @(posedge clk50) begin
    bus.read_ready <= 1'b0;
    if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
    if (bus.write && !stuck) begin
      mem[bus.waddr] <= bus.wdata;
      bcnt <= 3'd3;
    end
    if (bus.read && !stuck) begin
      bcnt  <= 3'd3;
      rpend <= 1'b1;
    end
    if (rpend && bcnt == 3'd2) begin
      bus.rdata      <= mem[bus.raddr];
      bus.read_ready <= 1'b1;
      rpend          <= 1'b0;
    end
  end
  // strobe monitor
  always @(posedge clk50) begin
    if (bus.write) begin
      wcnt <= wcnt + 1;
      last_waddr <= bus.waddr;
    end
    if (bus.read) begin
      rcnt <= rcnt + 1;
      last_raddr <= bus.raddr;
    end
    if (bus.write && bus.read) both <= both + 1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {bus.iready, bus.ovalid, bus.write, bus.read, bus.err, bus.state}, 0);
    chk("rst_data", {bus.odata, bus.wdata, 15'd0, bus.ochannel}, 0);
    chk("rst_addr", {bus.waddr, bus.raddr}, 0);
    @(negedge clk50);
    rst_n = 1'b1;
    m_wptr = 0;
    m_fill = 0;
    m_dlat = 0;
    @(negedge clk50);
  endtask
  task automatic accept(input int ch, input logic [15:0] d, input bit byp);
    int t;
    bus.ichannel = ch[0];
    bus.idata    = d;
    bus.bypass   = byp;
    bus.ivalid   = 1'b1;
    t = 0;
    while (bus.iready !== 1'b1 && t < 200) begin
      @(negedge clk50);
      t++;
    end
    if (t >= 200) chk("accept_timeout", 0, 1);
    @(negedge clk50);
    bus.ivalid = 1'b0;
  endtask
  task automatic send(input int ch, input logic [15:0] d, input bit byp, input bit stk, input int stall);
    int wp0, rp, t, wc0, rc0;
    logic [15:0] e;
    exp_t x;
    wp0 = m_wptr;
    rp = (m_wptr - m_dlat) & (DP - 1);
    if (byp) e = d;
    else begin
      if (!stk) mem_m[ch][m_wptr] = d;
      e = (stk || m_fill < m_dlat) ? 16'd0 : mem_m[ch][rp];
    end
    q.push_back('{ch[0], e});
    wc0 = wcnt;
    rc0 = rcnt;
    bus.oready = stall == 0;
    accept(ch, d, byp);
    if (byp) chk("byp_latency", bus.ovalid, 1);
    t = 0;
    while (bus.ovalid !== 1'b1 && t < 500) begin
      @(negedge clk50);
      t++;
    end
    if (t >= 500) chk("ovalid_timeout", 0, 1);
    x = q.pop_front();
    chk("odata", bus.odata, x.d);
    chk("ochannel", bus.ochannel, x.ch);
    if (byp) chk("byp_no_sdram", wcnt - wc0 + rcnt - rc0, 0);
    else if (!stk) begin
      chk("waddr", last_waddr, {ch[0], 4'(wp0)});
      chk("raddr", last_raddr, {ch[0], 4'(rp)});
      chk("wr_count", wcnt - wc0, 1);
      chk("rd_count", rcnt - rc0, 1);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk50);
      chk("stall_hold", {bus.ovalid, bus.iready, bus.ochannel, bus.odata}, {1'b1, 1'b0, x.ch, x.d});
    end
    bus.oready = 1'b1;
    if (ch == 1) begin
      m_wptr = (m_wptr + 1) % DP;
      if (m_fill < DP - 1) m_fill++;
      m_dlat = int'(bus.delay);
    end
    @(negedge clk50);
  endtask
  initial begin
    int t;
    for (int i = 0; i < 32; i++) mem[i] = 16'd0;
    for (int c = 0; c < 2; c++) for (int i = 0; i < DP; i++) mem_m[c][i] = 16'd0;
    bus.ivalid = 1'b0;
    bus.idata = '0;
    bus.ichannel = '0;
    bus.bypass = 1'b0;
    bus.oready = 1'b1;
    bus.delay = 4'd4;
    @(negedge clk50);
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      send(0, 16'(k), 0, 0, 0);
      send(1, 16'(100 + k), 0, 0, 0);
    end
    bus.delay = 4'd0;
    do_reset();
    send(0, 16'h1234, 0, 0, 0);
    send(1, 16'h5678, 0, 0, 0);
    send(0, 16'h00AA, 1, 0, 0);
    send(1, 16'h00BB, 1, 0, 0);
    send(0, 16'h0C0C, 0, 0, 0);
    send(1, 16'h0D0D, 0, 0, 0);
    bus.delay = 4'd15;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      send(0, 16'(k), 0, 0, 0);
      send(1, 16'(200 + k), 0, 0, 0);
    end
    bus.delay = 4'd0;
    do_reset();
    stuck = 1'b1;
    send(0, 16'h7777, 0, 1, 0);
    stuck = 1'b0;
    chk("err_set", bus.err, 1);
    send(1, 16'h1111, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      send(0, 16'(k + 16'h0300), 0, 0, 0);
      send(1, 16'(k + 16'h0400), 0, 0, 0);
      chk("err_sticky", bus.err, 1);
    end
    send(0, 16'h0A0A, 0, 0, 10);
    send(1, 16'h0B0B, 0, 0, 0);
    accept(0, 16'h4242, 0);
    t = 0;
    while (bus.state !== 3'd4 && t < 200) begin
      @(negedge clk50);
      t++;
    end
    chk("reach_wait_r", bus.state, 4);
    mem_m[0][m_wptr] = 16'h4242;
    do_reset();
    chk("err_cleared", bus.err, 0);
    send(0, 16'h5151, 0, 0, 0);
    send(1, 16'h5252, 0, 0, 0);
    chk("no_overlap", both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
